// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM cell-update datapath.
// Holds the Q-format constants, the FSM state type and a reference sat/shift helper.
package lstm_pkg;

    localparam int DATA_W  = 5;
    localparam int FRAC_W  = 2;
    localparam int ONE     = 1 << FRAC_W;
    localparam int SAT_MAX = (1 << (DATA_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DATA_W - 1));

    typedef enum logic [2:0] {
        IDLE,
        FC,
        IG,
        CU,
        OH,
        DONE
    } state_t;

    // Integer form of the shift/saturate rule, for constant evaluation.
    function automatic int sat_shift(input int x, input int sh, input int w);
        int v;
        int hi;
        int lo;
        v  = x >>> sh;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fx_shift_sat.sv
// Arithmetic right shift (floor) followed by saturation to a narrower signed word.
// Purely combinational; IN_W must be at least OUT_W.
module fx_shift_sat #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 5,
    parameter int SHIFT = 2
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAXV = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] MINV = IN_W'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W-1:0] shifted;

    always_comb begin
        shifted = din >>> SHIFT;
        if (shifted > MAXV)
            dout = MAXV[OUT_W-1:0];
        else if (shifted < MINV)
            dout = MINV[OUT_W-1:0];
        else
            dout = shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell/hidden state update: c = f*c + i*g, h = o*hardtanh(c).
// Elements are processed serially through one shared multiplier, four cycles per element.
module lstm_cell_update
    import lstm_pkg::*;
#(
    parameter int dataWidth  = DATA_W,
    parameter int fracWidth  = FRAC_W,
    parameter int hiddenSize = 3,
    parameter int gateWidth  = 2 * dataWidth + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear_state,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [gateWidth*hiddenSize-1:0]  f_gate,
    input  logic [gateWidth*hiddenSize-1:0]  i_gate,
    input  logic [gateWidth*hiddenSize-1:0]  g_gate,
    input  logic [gateWidth*hiddenSize-1:0]  o_gate,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [dataWidth*hiddenSize-1:0]  h_out,
    output logic [dataWidth*hiddenSize-1:0]  c_out
);

    localparam int IW = (hiddenSize > 1) ? $clog2(hiddenSize) : 1;
    localparam int PW = 2 * dataWidth;
    localparam logic [IW-1:0] LAST = IW'(hiddenSize - 1);
    localparam logic signed [dataWidth-1:0] POS_ONE = dataWidth'(1 << fracWidth);
    localparam logic signed [dataWidth-1:0] NEG_ONE = dataWidth'(-(1 << fracWidth));

    state_t state_q, state_d;
    logic [IW-1:0] idx_q;
    logic signed [gateWidth-1:0] acc_q;
    logic signed [dataWidth-1:0] fq [hiddenSize];
    logic signed [dataWidth-1:0] iq [hiddenSize];
    logic signed [dataWidth-1:0] gq [hiddenSize];
    logic signed [dataWidth-1:0] oq [hiddenSize];
    logic signed [dataWidth-1:0] c_q [hiddenSize];
    logic signed [dataWidth-1:0] h_q [hiddenSize];
    logic signed [dataWidth-1:0] f_new [hiddenSize];
    logic signed [dataWidth-1:0] i_new [hiddenSize];
    logic signed [dataWidth-1:0] g_new [hiddenSize];
    logic signed [dataWidth-1:0] o_new [hiddenSize];

    logic signed [dataWidth-1:0] mul_a, mul_b, c_sel, t_clamp, c_wb, h_wb;
    logic signed [PW-1:0] prod;

    for (genvar k = 0; k < hiddenSize; k++) begin : g_quant
        fx_shift_sat #(.IN_W(gateWidth), .OUT_W(dataWidth), .SHIFT(fracWidth)) u_qf (
            .din(f_gate[gateWidth*k +: gateWidth]), .dout(f_new[k]));
        fx_shift_sat #(.IN_W(gateWidth), .OUT_W(dataWidth), .SHIFT(fracWidth)) u_qi (
            .din(i_gate[gateWidth*k +: gateWidth]), .dout(i_new[k]));
        fx_shift_sat #(.IN_W(gateWidth), .OUT_W(dataWidth), .SHIFT(fracWidth)) u_qg (
            .din(g_gate[gateWidth*k +: gateWidth]), .dout(g_new[k]));
        fx_shift_sat #(.IN_W(gateWidth), .OUT_W(dataWidth), .SHIFT(fracWidth)) u_qo (
            .din(o_gate[gateWidth*k +: gateWidth]), .dout(o_new[k]));
    end

    // hardtanh on the freshly written cell value feeds the OH multiply
    always_comb begin
        c_sel = c_q[idx_q];
        if (c_sel > POS_ONE)
            t_clamp = POS_ONE;
        else if (c_sel < NEG_ONE)
            t_clamp = NEG_ONE;
        else
            t_clamp = c_sel;
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            FC: begin mul_a = fq[idx_q]; mul_b = c_sel;   end
            IG: begin mul_a = iq[idx_q]; mul_b = gq[idx_q]; end
            OH: begin mul_a = oq[idx_q]; mul_b = t_clamp; end
            default: ;
        endcase
    end

    assign prod = mul_a * mul_b;

    fx_shift_sat #(.IN_W(gateWidth), .OUT_W(dataWidth), .SHIFT(fracWidth)) u_cu (
        .din(acc_q), .dout(c_wb));
    fx_shift_sat #(.IN_W(PW), .OUT_W(dataWidth), .SHIFT(fracWidth)) u_oh (
        .din(prod), .dout(h_wb));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = FC;
            FC:   state_d = IG;
            IG:   state_d = CU;
            CU:   state_d = OH;
            OH:   state_d = (idx_q == LAST) ? DONE : FC;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = rst && (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            acc_q <= '0;
            for (int unsigned k = 0; k < hiddenSize; k++) begin
                fq[k] <= '0; iq[k] <= '0; gq[k] <= '0; oq[k] <= '0;
                c_q[k] <= '0; h_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_state) begin
                        for (int unsigned k = 0; k < hiddenSize; k++) begin
                            c_q[k] <= '0;
                            h_q[k] <= '0;
                        end
                    end
                    if (in_valid) begin
                        idx_q <= '0;
                        for (int unsigned k = 0; k < hiddenSize; k++) begin
                            fq[k] <= f_new[k]; iq[k] <= i_new[k];
                            gq[k] <= g_new[k]; oq[k] <= o_new[k];
                        end
                    end
                end
                FC: acc_q <= gateWidth'(prod);
                IG: acc_q <= acc_q + gateWidth'(prod);
                CU: c_q[idx_q] <= c_wb;
                OH: begin
                    h_q[idx_q] <= h_wb;
                    if (idx_q != LAST) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        h_out = '0;
        c_out = '0;
        for (int unsigned k = 0; k < hiddenSize; k++) begin
            h_out[dataWidth*k +: dataWidth] = h_q[k];
            c_out[dataWidth*k +: dataWidth] = c_q[k];
        end
    end

endmodule

// File: tb/tb_lstm_cell_update.sv
// Self-checking bench for lstm_cell_update: directed and random steps against an integer model.
module tb_lstm_cell_update;

    localparam int DW = 5;
    localparam int FW = 2;
    localparam int HS = 3;
    localparam int GW = 2 * DW + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear_state = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [GW*HS-1:0] f_gate = '0;
    logic [GW*HS-1:0] i_gate = '0;
    logic [GW*HS-1:0] g_gate = '0;
    logic [GW*HS-1:0] o_gate = '0;
    logic [DW*HS-1:0] h_out, c_out;

    int passed = 0;
    int total = 0;
    int fv[HS], iv[HS], gv[HS], ov[HS];
    int mc[HS], mh[HS];

    lstm_cell_update #(.dataWidth(DW), .fracWidth(FW), .hiddenSize(HS)) dut (
        .clk(clk), .rst(rst), .clear_state(clear_state),
        .in_valid(in_valid), .in_ready(in_ready),
        .f_gate(f_gate), .i_gate(i_gate), .g_gate(g_gate), .o_gate(o_gate),
        .out_valid(out_valid), .out_ready(out_ready),
        .h_out(h_out), .c_out(c_out));

    always #5 clk = ~clk;

    function automatic int floordiv(input int x, input int d);
        int q;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat(input int x);
        int hi;
        int lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic int quant(input int g);
        return sat(floordiv(g, 1 << FW));
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_step(input bit clr);
        int one, t;
        one = 1 << FW;
        if (clr) begin
            for (int k = 0; k < HS; k++) begin mc[k] = 0; mh[k] = 0; end
        end
        for (int k = 0; k < HS; k++) begin
            mc[k] = sat(floordiv(quant(fv[k]) * mc[k] + quant(iv[k]) * quant(gv[k]), one));
            t = (mc[k] > one) ? one : ((mc[k] < -one) ? -one : mc[k]);
            mh[k] = sat(floordiv(quant(ov[k]) * t, one));
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < HS; k++) begin
            chk($sformatf("%s c[%0d]", tag, k), $signed(c_out[DW*k +: DW]), mc[k]);
            chk($sformatf("%s h[%0d]", tag, k), $signed(h_out[DW*k +: DW]), mh[k]);
        end
    endtask

    task automatic drive_gates();
        for (int k = 0; k < HS; k++) begin
            f_gate[GW*k +: GW] = GW'(fv[k]);
            i_gate[GW*k +: GW] = GW'(iv[k]);
            g_gate[GW*k +: GW] = GW'(gv[k]);
            o_gate[GW*k +: GW] = GW'(ov[k]);
        end
    endtask

    task automatic scramble_gates();
        for (int k = 0; k < HS; k++) begin
            f_gate[GW*k +: GW] = GW'($urandom);
            i_gate[GW*k +: GW] = GW'($urandom);
            g_gate[GW*k +: GW] = GW'($urandom);
            o_gate[GW*k +: GW] = GW'($urandom);
        end
    endtask

    task automatic set_all(input int f, input int i, input int g, input int o);
        for (int k = 0; k < HS; k++) begin fv[k] = f; iv[k] = i; gv[k] = g; ov[k] = o; end
    endtask

    task automatic randomize_gates();
        for (int k = 0; k < HS; k++) begin
            fv[k] = int'($urandom_range(0, 2047)) - 1024;
            iv[k] = int'($urandom_range(0, 2047)) - 1024;
            gv[k] = int'($urandom_range(0, 2047)) - 1024;
            ov[k] = int'($urandom_range(0, 2047)) - 1024;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, " ready"}, in_ready, 1);
    endtask

    // One full step; hold_valid keeps in_valid/gates asserted through the computation.
    task automatic do_step(input bit clr, input bit hold_valid, input int hold_done, input string tag);
        int n;
        out_ready = 1'b0;
        wait_ready(tag);
        drive_gates();
        in_valid = 1'b1;
        clear_state = clr;
        @(posedge clk); #1;
        model_step(clr);
        clear_state = 1'b0;
        if (!hold_valid) begin
            in_valid = 1'b0;
            scramble_gates();
        end
        chk({tag, " accepted"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk({tag, " latency"}, n, 4 * HS);
        check_outputs(tag);
        chk({tag, " in_ready in DONE"}, in_ready, 0);
        for (int j = 0; j < hold_done; j++) begin
            @(posedge clk); #1;
            chk({tag, " hold out_valid"}, out_valid, 1);
            chk({tag, " hold in_ready"}, in_ready, 0);
            check_outputs({tag, " hold"});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " released"}, out_valid, 0);
        chk({tag, " idle ready"}, in_ready, 1);
    endtask

    initial begin
        bit pulsed;
        for (int k = 0; k < HS; k++) begin mc[k] = 0; mh[k] = 0; end

        #12;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset c_out", c_out, 0);
        chk("reset h_out", h_out, 0);
        #10 rst = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", in_ready, 1);

        set_all(16, 16, 8, 16);
        do_step(1'b0, 1'b0, 0, "basic1");
        chk("basic1 c0 const", $signed(c_out[DW-1:0]), 2);
        chk("basic1 h0 const", $signed(h_out[DW-1:0]), 2);
        do_step(1'b0, 1'b0, 0, "basic2");
        chk("basic2 c0 const", $signed(c_out[DW-1:0]), 4);
        do_step(1'b0, 1'b0, 5, "basic3");
        chk("basic3 c0 const", $signed(c_out[DW-1:0]), 6);
        chk("basic3 h0 const", $signed(h_out[DW-1:0]), 4);

        set_all(16, 16, 60, 16);
        for (int s = 0; s < 3; s++) do_step(1'b0, 1'b0, 0, $sformatf("sat%0d", s));
        chk("sat c2 const", $signed(c_out[DW*2 +: DW]), 15);
        chk("sat h2 const", $signed(h_out[DW*2 +: DW]), 4);

        clear_state = 1'b1;
        @(posedge clk); #1;
        clear_state = 1'b0;
        for (int k = 0; k < HS; k++) begin mc[k] = 0; mh[k] = 0; end
        check_outputs("clear");

        set_all(16, 16, -8, 4);
        gv[2] = -100;
        ov[2] = 16;
        do_step(1'b0, 1'b0, 0, "neg");
        chk("neg c0 const", $signed(c_out[DW-1:0]), -2);
        chk("neg h0 const", $signed(h_out[DW-1:0]), -1);
        chk("neg c2 const", $signed(c_out[DW*2 +: DW]), -16);

        set_all(16, 16, 8, 16);
        do_step(1'b0, 1'b1, 0, "held");
        do_step(1'b0, 1'b0, 0, "held2");

        for (int s = 0; s < 6; s++) begin
            randomize_gates();
            do_step(1'b0, 1'b0, (s == 2) ? 2 : 0, $sformatf("rand%0d", s));
        end

        set_all(16, 16, 60, 16);
        wait_ready("abort");
        drive_gates();
        in_valid = 1'b1;
        clear_state = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_state = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort pre c0", $signed(c_out[DW-1:0]), 15);
        rst = 1'b0;
        #1;
        chk("abort c_out", c_out, 0);
        chk("abort h_out", h_out, 0);
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 0);
        #1 rst = 1'b1;
        for (int k = 0; k < HS; k++) begin mc[k] = 0; mh[k] = 0; end
        pulsed = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) pulsed = 1'b1;
        end
        chk("abort no out_valid", pulsed, 0);

        randomize_gates();
        do_step(1'b0, 1'b0, 0, "pre-clr");
        randomize_gates();
        do_step(1'b1, 1'b0, 0, "clr-accept");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
